// File: rtl/seg7_scan_mux_pkg.sv
// Shared definitions for the 7-segment scan multiplexer: register map,
// CTRL field positions and the hex -> active-low segment table.
package seg7_scan_mux_pkg;

    typedef enum logic [1:0] {
        REG_DATA  = 2'd0,
        REG_DP    = 2'd1,
        REG_BLANK = 2'd2,
        REG_CTRL  = 2'd3
    } reg_e;

    localparam int CTRL_LZS_BIT = 8;

    // Returns {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return ~s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Registered nibble -> active-low segment decoder (one clock of latency).
module seg7_hex_decode
    import seg7_scan_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    logic [6:0] seg_d, seg_q;

    always_comb seg_d = hex_to_seg_n(nib);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) seg_q <= 7'h7F;
        else     seg_q <= seg_d;
    end

    assign seg_n = seg_q;

endmodule

// File: rtl/seg7_scan_mux.sv
// Memory-mapped, time-multiplexed common-anode 7-segment driver with PWM
// brightness, leading-zero suppression, anti-ghost dead time and read-back.
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int          NDIGITS = 8,
    parameter logic [31:0] BASE    = 32'h100,
    parameter int          DIVBITS = 16,
    parameter int          PWMBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               rw,
    input  logic [31:0]        addr,
    input  logic [31:0]        data,
    output logic [31:0]        q,
    output logic [7:0]         seg,
    output logic [NDIGITS-1:0] an
);

    localparam int SELW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NDIGITS - 1);

    logic [4*NDIGITS-1:0] data_q, data_d;
    logic [NDIGITS-1:0]   dp_q, dp_d, blank_q, blank_d;
    logic [PWMBITS-1:0]   bright_q, bright_d;
    logic                 lzs_q, lzs_d;
    logic [31:0]          q_q, q_d;
    logic [DIVBITS-1:0]   pre_q, pre_d;
    logic [SELW-1:0]      sel_q, sel_d, sel_s1_q, sel_s1_d;
    logic                 on_s1_q, on_s1_d, dp_s1_q, dp_s1_d;
    logic [7:0]           seg_q, seg_d;
    logic [NDIGITS-1:0]   an_q, an_d;

    logic [31:0]               off, rd_val;
    logic                      in_range;
    reg_e                      reg_sel;
    logic [NDIGITS-1:0][3:0]   nibs;
    logic [3:0]                cur_nib;
    logic [6:0]                hex_seg_n;
    logic [PWMBITS-1:0]        phase;
    logic                      pwm_on;
    logic [NDIGITS-1:0]        lz_dark;

    assign off      = addr - BASE;
    assign in_range = (addr >= BASE) && (off < 32'd4);
    assign reg_sel  = reg_e'(off[1:0]);
    assign nibs     = data_q;

    always_comb begin
        data_d   = data_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        bright_d = bright_q;
        lzs_d    = lzs_q;
        q_d      = q_q;
        rd_val   = '0;
        case (reg_sel)
            REG_DATA:  rd_val[4*NDIGITS-1:0] = data_q;
            REG_DP:    rd_val[NDIGITS-1:0]   = dp_q;
            REG_BLANK: rd_val[NDIGITS-1:0]   = blank_q;
            REG_CTRL: begin
                rd_val[PWMBITS-1:0]  = bright_q;
                rd_val[CTRL_LZS_BIT] = lzs_q;
            end
            default: ;
        endcase
        if (enable && in_range) begin
            if (rw) begin
                case (reg_sel)
                    REG_DATA:  data_d  = data[4*NDIGITS-1:0];
                    REG_DP:    dp_d    = data[NDIGITS-1:0];
                    REG_BLANK: blank_d = data[NDIGITS-1:0];
                    REG_CTRL: begin
                        bright_d = data[PWMBITS-1:0];
                        lzs_d    = data[CTRL_LZS_BIT];
                    end
                    default: ;
                endcase
            end else begin
                q_d = rd_val;
            end
        end
    end

    // Stage 1 decides whether the current slot is lit; stage 2 drives the pins
    // in step with the registered hex decoder.
    always_comb begin
        pre_d = pre_q + 1'b1;
        sel_d = sel_q;
        if (pre_q == '1) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

        phase  = pre_q[DIVBITS-1 -: PWMBITS];
        pwm_on = (bright_q == '1) || (phase < bright_q);
        for (int i = 0; i < NDIGITS; i++)
            lz_dark[i] = lzs_q && (i != 0) && ((data_q >> (4 * i)) == '0);

        cur_nib  = nibs[sel_q];
        on_s1_d  = (pre_q != '0) && pwm_on && !blank_q[sel_q] && !lz_dark[sel_q];
        dp_s1_d  = dp_q[sel_q];
        sel_s1_d = sel_q;

        seg_d = on_s1_q ? {~dp_s1_q, hex_seg_n} : 8'hFF;
        an_d  = '1;
        if (on_s1_q) an_d[sel_s1_q] = 1'b0;
    end

    seg7_hex_decode u_dec (
        .clk   (clk),
        .rst   (reset),
        .nib   (cur_nib),
        .seg_n (hex_seg_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            bright_q <= '1;
            lzs_q    <= 1'b0;
            q_q      <= '0;
            pre_q    <= '0;
            sel_q    <= '0;
            sel_s1_q <= '0;
            on_s1_q  <= 1'b0;
            dp_s1_q  <= 1'b0;
            seg_q    <= 8'hFF;
            an_q     <= '1;
        end else begin
            data_q   <= data_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            bright_q <= bright_d;
            lzs_q    <= lzs_d;
            q_q      <= q_d;
            pre_q    <= pre_d;
            sel_q    <= sel_d;
            sel_s1_q <= sel_s1_d;
            on_s1_q  <= on_s1_d;
            dp_s1_q  <= dp_s1_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign q   = q_q;
    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: register table, directed scan scenarios and random
// bus traffic, all checked cycle by cycle against a cycle-count based model.
module tb_seg7_scan_mux;

    localparam int          ND   = 8;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          DB   = 6;
    localparam int          PB   = 4;
    localparam int          SLOT = 1 << DB;

    logic        clk = 0, reset = 0, enable = 0, rw = 0;
    logic [31:0] addr = 0, data = 0;
    logic [31:0] q;
    logic [7:0]  seg;
    logic [ND-1:0] an;

    seg7_scan_mux #(.NDIGITS(ND), .BASE(BASE), .DIVBITS(DB), .PWMBITS(PB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rw(rw), .addr(addr),
        .data(data), .q(q), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int k;
    logic [31:0] m_data, q_m;
    logic [7:0]  m_dp, m_blank;
    logic [3:0]  m_bright;
    logic        m_lzs;
    logic [15:0] exp_q[$];
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        string       name;
        logic [31:0] wa, wd, ra, exp_q;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pins expected from the state k cycles after reset release.
    function automatic logic [15:0] model_pins();
        int pre = k % SLOT;
        int d = (k / SLOT) % ND;
        logic [3:0] nib;
        logic [7:0] an_m;
        bit on;
        nib  = m_data[4*d +: 4];
        on   = (pre != 0) && (m_bright == 4'hF || (pre / (SLOT >> PB)) < m_bright)
               && !m_blank[d] && !(m_lzs && d > 0 && (m_data >> (4 * d)) == 0);
        an_m = 8'hFF;
        an_m[d] = 1'b0;
        if (!on) return 16'hFFFF;
        return {~m_dp[d], ~hex_tab[nib], an_m};
    endfunction

    task automatic model_bus(input logic en, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] o;
        if (en && a >= BASE && a < BASE + 4) begin
            o = a - BASE;
            if (wr) begin
                case (o)
                    0: m_data = d;
                    1: m_dp = d[7:0];
                    2: m_blank = d[7:0];
                    default: begin m_bright = d[3:0]; m_lzs = d[8]; end
                endcase
            end else begin
                case (o)
                    0: q_m = m_data;
                    1: q_m = {24'h0, m_dp};
                    2: q_m = {24'h0, m_blank};
                    default: q_m = {23'h0, m_lzs, 4'h0, m_bright};
                endcase
            end
        end
    endtask

    // Called at a negedge; returns at the next negedge after checking pins and q.
    task automatic step(input logic en, input logic wr, input logic [31:0] a, input logic [31:0] d);
        enable = en; rw = wr; addr = a; data = d;
        exp_q.push_back(model_pins());
        @(posedge clk);
        model_bus(en, wr, a, d);
        k++;
        @(negedge clk);
        chk("pins", {16'h0, seg, an}, {16'h0, exp_q.pop_front()});
        chk("q", q, q_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        enable = 0;
        reset = 1;
        #1;
        chk("rst_an", {24'h0, an}, 32'hFF);
        chk("rst_seg", {24'h0, seg}, 32'hFF);
        chk("rst_q", q, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        k = 0; m_data = 0; m_dp = 0; m_blank = 0; m_bright = 4'hF; m_lzs = 0; q_m = 0;
        exp_q.delete();
        exp_q.push_back(16'hFFFF);
    endtask

    initial begin
        logic [7:0] seen [ND];
        logic [7:0] exp_seen [ND];
        logic [7:0] lit;
        int cnt, cnt_b, first_n;
        logic [7:0] first_an;

        vecs[0] = '{"rd_data",     BASE,     32'h0000_12AF, BASE,     32'h0000_12AF};
        vecs[1] = '{"rd_dp",       BASE + 1, 32'hFFFF_FF01, BASE + 1, 32'h0000_0001};
        vecs[2] = '{"rd_blank",    BASE + 2, 32'h1234_5602, BASE + 2, 32'h0000_0002};
        vecs[3] = '{"rd_ctrl_all", BASE + 3, 32'hFFFF_FFFF, BASE + 3, 32'h0000_010F};
        vecs[4] = '{"rd_ctrl",     BASE + 3, 32'h0000_0205, BASE + 3, 32'h0000_0005};
        vecs[5] = '{"oob_hi",      BASE + 4, 32'hDEAD_BEEF, BASE,     32'h0000_12AF};
        vecs[6] = '{"oob_lo",      BASE - 1, 32'hFFFF_FFFF, BASE + 2, 32'h0000_0002};
        vecs[7] = '{"rd_data2",    BASE,     32'h8765_4321, BASE,     32'h8765_4321};
        exp_seen = '{8'h8E, 8'h88, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

        #2;
        do_reset();
        idle(3);

        for (int i = 0; i < 8; i++) begin
            step(1, 1, vecs[i].wa, vecs[i].wd);
            step(1, 0, vecs[i].ra, 32'h0);
            chk(vecs[i].name, q, vecs[i].exp_q);
        end

        // out-of-range read leaves q alone
        step(1, 0, BASE + 2, 32'h0);
        step(1, 0, BASE + 5, 32'h0);
        chk("oob_read_q", q, 32'h2);

        // hex display of 0x12AF on all digits
        step(1, 1, BASE, 32'h0000_12AF);
        step(1, 1, BASE + 1, 32'h0);
        step(1, 1, BASE + 2, 32'h0);
        step(1, 1, BASE + 3, 32'h0F);
        idle(4);
        for (int d = 0; d < ND; d++) seen[d] = 8'h00;
        for (int i = 0; i < ND * SLOT + 8; i++) begin
            idle(1);
            for (int d = 0; d < ND; d++)
                if (an == ~(8'd1 << d)) seen[d] = seg;
        end
        for (int d = 0; d < ND; d++) chk($sformatf("digit%0d_seg", d), {24'h0, seen[d]}, {24'h0, exp_seen[d]});

        // leading-zero suppression
        step(1, 1, BASE, 32'h0);
        step(1, 1, BASE + 3, 32'h10F);
        idle(4);
        lit = 0;
        for (int i = 0; i < ND * SLOT; i++) begin idle(1); lit |= ~an; end
        chk("lzs_zero_lit", {24'h0, lit}, 32'h01);
        step(1, 1, BASE, 32'h0000_0100);
        idle(4);
        lit = 0;
        for (int i = 0; i < ND * SLOT; i++) begin idle(1); lit |= ~an; end
        chk("lzs_100_lit", {24'h0, lit}, 32'h07);

        // PWM duty
        step(1, 1, BASE + 3, 32'h004);
        idle(4);
        cnt = 0;
        for (int i = 0; i < ND * SLOT; i++) begin idle(1); if (an == 8'hFB) cnt++; end
        chk("pwm4_cycles", cnt, 15);
        step(1, 1, BASE + 3, 32'h000);
        idle(4);
        lit = 0;
        for (int i = 0; i < ND * SLOT; i++) begin idle(1); lit |= ~an; end
        chk("pwm0_lit", {24'h0, lit}, 32'h00);

        // blank and decimal point
        step(1, 1, BASE + 3, 32'h00F);
        step(1, 1, BASE + 2, 32'h02);
        step(1, 1, BASE + 1, 32'h01);
        idle(4);
        cnt = 0; cnt_b = 0; lit = 0;
        for (int i = 0; i < ND * SLOT; i++) begin
            idle(1);
            lit |= ~an;
            if (an == 8'hFE) begin cnt++; if (seg[7]) cnt_b++; end
        end
        chk("blank_d1", {31'h0, lit[1]}, 32'h0);
        chk("d0_lit_cycles", cnt, SLOT - 1);
        chk("d0_dp_off", cnt_b, 0);
        step(1, 0, BASE + 2, 32'h0);
        chk("rd_blank_q", q, 32'h02);

        // random bus traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                logic [31:0] a;
                int s = $urandom_range(0, 7);
                a = (s < 6) ? BASE + 32'(s) : (s == 6) ? BASE - 1 : $urandom;
                step(1, 1'($urandom_range(0, 1)), a, $urandom);
            end else begin
                idle(1);
            end
        end

        // asynchronous reset in the middle of digit 3's slot
        step(1, 1, BASE + 3, 32'h0F);
        step(1, 0, BASE + 3, 32'h0);
        for (int i = 0; i < ND * SLOT && (k % (ND * SLOT)) != 3 * SLOT + 20; i++) idle(1);
        chk("pre_rst_an", {24'h0, an}, 32'hF7);
        #2;
        do_reset();
        first_n = 0; first_an = 8'hFF;
        for (int i = 1; i <= 8; i++) begin
            idle(1);
            if (first_n == 0 && an != 8'hFF) begin first_n = i; first_an = an; end
        end
        chk("first_lit_cycle", first_n, 3);
        chk("first_lit_an", {24'h0, first_an}, 32'hFE);
        idle(SLOT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
